add_acc_pipe: RTL and testbench
===============================

// Module: add_acc_pipe
// PURPOSE
//  Parametrised registered adder with valid/ready handshake and an accumulate mode.
//  In add mode it returns a+b one cycle after the input is accepted.
//  In accumulate mode it sums a multi-beat packet and emits one result on the beat tagged last.
//  It sits between a producer and a consumer stream and replaces the fixed-width free-running adder.
// PARAMETERS
//  WIDTH     4   width of operands a, b
//  ACC_BITS  4   extra headroom bits; result width SW = WIDTH+ACC_BITS
//  CNT_W     4   width of beat counter output
// PORTS
//  clk        in   1      clock, all state on rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      input beat valid
//  in_ready   out  1      block can accept a beat this cycle
//  a          in   WIDTH  operand, unsigned
//  b          in   WIDTH  operand, unsigned
//  mode       in   1      0 = add (single beat), 1 = accumulate
//  last       in   1      final beat of accumulate packet (ignored when mode=0)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  SW     result, unsigned
//  out_cnt    out  CNT_W  beats contributing to result
//  out_ovf    out  1      result exceeded 2^SW-1 at some step
// BEHAVIOUR
//  - Reset (async, rst=1):
//      out_valid=0, sum=0, out_cnt=0, out_ovf=0; acc=0, acc_cnt=0, acc_ovf=0; state IDLE.
//  - Accept condition: in_ready = !out_valid || out_ready (combinational).
//      A beat is accepted when in_valid && in_ready.
//  - Output register: out_valid is cleared on out_valid && out_ready when no new result is loaded.
//      While out_valid && !out_ready, sum/out_cnt/out_ovf stay stable and in_ready=0.
//      Full throughput is one beat per cycle when out_ready=1.
//  - Arithmetic: every add is computed in SW+1 bits.
//      A carry out of bit SW-1 sets the overflow flag and the result wraps modulo 2^SW.
//  - FSM states: IDLE and ACCUM.
//  - Add-mode beat (mode=0), legal in either state:
//      next cycle out_valid=1, sum=a+b, out_cnt=1, out_ovf=0.
//      acc, acc_cnt, acc_ovf and state are untouched.
//  - IDLE, mode=1, last=0:
//      acc=a+b, acc_cnt=1, acc_ovf=0; go to ACCUM; no output.
//  - IDLE, mode=1, last=1: single-beat packet.
//      Output sum=a+b, out_cnt=1; stay in IDLE.
//  - ACCUM, mode=1, last=0:
//      acc+=a+b; acc_cnt+=1, saturating at 2^CNT_W-1; acc_ovf|=carry.
//  - ACCUM, mode=1, last=1:
//      output sum=acc+a+b, out_cnt=acc_cnt+1 (saturating), out_ovf=acc_ovf|carry.
//      Clear acc, acc_cnt and acc_ovf; go to IDLE.
//  - Latency: one cycle from the accepting edge to out_valid for every emitting beat.
//  - Reset mid-packet: the partial accumulation is discarded, with no output.
//  - Any pending out_valid is dropped.
// CONFIGURATION
//  ADD_ACC_SAT_EN
//  - Defined: on any step with a carry, the result (acc or sum) is clamped to 2^SW-1.
//      Further accumulation in that packet stays at 2^SW-1; out_ovf=1 still reported.
//  - Undefined: wrap modulo 2^SW as above; out_ovf=1 reported.
// TESTING (WIDTH=4, ACC_BITS=4, CNT_W=4, out_ready=1 unless stated)
//  1. Add mode:
//     mode=0, a=9, b=8 -> next cycle out_valid=1, sum=17, out_cnt=1, out_ovf=0.
//  2. Accumulate packet:
//     (15,15), (15,15), then (1,0) with last=1 -> no output on beats 1-2.
//     One output sum=61, out_cnt=3.
//  3. Overflow:
//     9 beats of (15,15), last on the 9th -> total 270.
//     Wrap build: sum=14, out_cnt=9, out_ovf=1.
//     With ADD_ACC_SAT_EN: sum=255, out_ovf=1.
//  4. Backpressure:
//     result valid with out_ready=0 for 3 cycles -> sum held, in_ready=0, next beat stalls.
//     out_ready=1 -> result consumed and stalled beat accepted in the same cycle.
//  5. Reset mid-packet:
//     2 accumulate beats (5,5), then pulse rst -> out_valid=0 immediately.
//     Then mode=1, last=1, (3,4) -> sum=7, out_cnt=1.
//  6. Interleave:
//     ACCUM with acc=20, then mode=0 beat (2,3) -> sum=5 out.
//     Then (1,1) with last=1 -> sum=22, out_cnt=2.

Source files
------------

// File: rtl/add_acc_pipe_if.sv
// Stream bundle for add_acc_pipe: input beat handshake (a, b, mode, last) and result handshake.
interface add_acc_pipe_if #(
    parameter int WIDTH    = 4,
    parameter int ACC_BITS = 4,
    parameter int CNT_W    = 4
);
    localparam int SW = WIDTH + ACC_BITS;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mode;
    logic             last;
    logic             out_valid;
    logic             out_ready;
    logic [SW-1:0]    sum;
    logic [CNT_W-1:0] out_cnt;
    logic             out_ovf;

    modport master (
        output in_valid, a, b, mode, last, out_ready,
        input  in_ready, out_valid, sum, out_cnt, out_ovf
    );

    modport slave (
        input  in_valid, a, b, mode, last, out_ready,
        output in_ready, out_valid, sum, out_cnt, out_ovf
    );
endinterface

// File: rtl/add_acc_pipe.sv
// Registered adder / packet accumulator with valid/ready on both sides.
// Define ADD_ACC_SAT_EN to clamp results at 2^SW-1 on carry instead of wrapping.
//
// state | meaning
// IDLE  | no accumulate packet open
// ACCUM | packet open, acc_q holds the partial sum
module add_acc_pipe #(
    parameter int WIDTH    = 4,
    parameter int ACC_BITS = 4,
    parameter int CNT_W    = 4
) (
    input  logic          clk,
    input  logic          rst,
    add_acc_pipe_if.slave bus
);
    localparam int SW = WIDTH + ACC_BITS;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [SW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    sum_q, sum_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_ovf_q, out_ovf_d;

    logic             in_ready_w;
    logic             accept;
    logic             in_pkt;
    logic [SW:0]      ab_ext;
    logic [SW:0]      step_full;
    logic             step_carry;
    logic [SW-1:0]    step_val;
    logic [CNT_W-1:0] step_cnt;
    logic             step_ovf;

    assign in_ready_w = !out_valid_q || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_w;

    // Only an accumulate beat inside an open packet builds on the stored partial sum.
    assign in_pkt     = bus.mode && (state_q == ACCUM);
    assign ab_ext     = (SW+1)'(bus.a) + (SW+1)'(bus.b);
    assign step_full  = (in_pkt ? {1'b0, acc_q} : '0) + ab_ext;
    assign step_carry = step_full[SW];

`ifdef ADD_ACC_SAT_EN
    assign step_val = step_carry ? {SW{1'b1}} : step_full[SW-1:0];
`else
    assign step_val = step_full[SW-1:0];
`endif

    assign step_cnt = !in_pkt               ? CNT_W'(1)  :
                      (acc_cnt_q == '1)     ? acc_cnt_q  :
                                              acc_cnt_q + CNT_W'(1);
    assign step_ovf = (in_pkt && acc_ovf_q) || step_carry;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_cnt_d   = acc_cnt_q;
        acc_ovf_d   = acc_ovf_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        out_cnt_d   = out_cnt_q;
        out_ovf_d   = out_ovf_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (!bus.mode) begin
                out_valid_d = 1'b1;
                sum_d       = step_val;
                out_cnt_d   = CNT_W'(1);
                out_ovf_d   = step_ovf;
            end else if (bus.last) begin
                out_valid_d = 1'b1;
                sum_d       = step_val;
                out_cnt_d   = step_cnt;
                out_ovf_d   = step_ovf;
                acc_d       = '0;
                acc_cnt_d   = '0;
                acc_ovf_d   = 1'b0;
                state_d     = IDLE;
            end else begin
                acc_d       = step_val;
                acc_cnt_d   = step_cnt;
                acc_ovf_d   = step_ovf;
                state_d     = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            acc_cnt_q   <= '0;
            acc_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            out_cnt_q   <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_cnt_q   <= acc_cnt_d;
            acc_ovf_q   <= acc_ovf_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            out_cnt_q   <= out_cnt_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_add_acc_pipe.sv
// Scoreboard bench for add_acc_pipe: packet-level reference model feeds an expected queue,
// a negedge monitor pops and compares every result transfer.
module tb_add_acc_pipe;
    localparam int WIDTH    = 4;
    localparam int ACC_BITS = 4;
    localparam int CNT_W    = 4;
    localparam int SW       = WIDTH + ACC_BITS;
    localparam int MAXS     = (1 << SW) - 1;
    localparam int MAXC     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;

    add_acc_pipe_if #(.WIDTH(WIDTH), .ACC_BITS(ACC_BITS), .CNT_W(CNT_W)) bus ();

    add_acc_pipe #(.WIDTH(WIDTH), .ACC_BITS(ACC_BITS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned sum;
        int unsigned cnt;
        bit          ovf;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int unsigned pk_total = 0;
    int unsigned pk_n = 0;
    bit          rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Packet-level reference: true integer total, then wrap or clamp once at emission.
    function automatic void push_result(input int unsigned total, input int unsigned n);
        exp_t e;
`ifdef ADD_ACC_SAT_EN
        e.sum = (total > MAXS) ? MAXS : total;
`else
        e.sum = total % (MAXS + 1);
`endif
        e.cnt = (n > MAXC) ? MAXC : n;
        e.ovf = (total > MAXS);
        exp_q.push_back(e);
    endfunction

    function automatic void model_beat(input int unsigned a, input int unsigned b,
                                       input bit mode, input bit last);
        if (!mode) begin
            push_result(a + b, 1);
        end else begin
            pk_total += a + b;
            pk_n++;
            if (last) begin
                push_result(pk_total, pk_n);
                pk_total = 0;
                pk_n = 0;
            end
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input bit mode, input bit last);
        int guard;
        bit ok;
        bus.a        = a;
        bus.b        = b;
        bus.mode     = mode;
        bus.last     = last;
        bus.in_valid = 1'b1;
        guard = 0;
        ok = 1'b0;
        while (!ok && guard < 100) begin
            @(negedge clk);
            ok = (bus.in_ready === 1'b1);
            guard++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, required 1", bus.in_ready, guard);
        end else begin
            model_beat(int'(a), int'(b), mode, last);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got sum=%0d cnt=%0d, required no output",
                             bus.sum, bus.out_cnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum", 32'(bus.sum), e.sum);
                    chk("out_cnt", 32'(bus.out_cnt), e.cnt);
                    chk("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        longint t0;
        int guard;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.mode      = 1'b0;
        bus.last      = 1'b0;
        bus.out_ready = 1'b1;

        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_out_cnt", 32'(bus.out_cnt), 0);
        chk("rst_out_ovf", 32'(bus.out_ovf), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(9, 8, 0, 0);
        chk("add_latency_valid", 32'(bus.out_valid), 1);

        send(15, 15, 1, 0);
        chk("pkt_beat1_no_out", 32'(bus.out_valid), 0);
        send(15, 15, 1, 0);
        chk("pkt_beat2_no_out", 32'(bus.out_valid), 0);
        send(1, 0, 1, 1);
        chk("pkt_last_valid", 32'(bus.out_valid), 1);

        for (int i = 0; i < 9; i++) send(15, 15, 1, (i == 8));

        idle(2);
        bus.out_ready = 1'b0;
        send(4, 7, 0, 0);
        bus.a        = 2;
        bus.b        = 3;
        bus.mode     = 1'b0;
        bus.last     = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_hold_sum", 32'(bus.sum), 4 + 7);
            chk("bp_hold_valid", 32'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        t0 = $time;
        send(2, 3, 0, 0);
        chk("bp_same_cycle_ns", 32'($time - t0), 10);

        send(5, 5, 1, 0);
        send(5, 5, 1, 0);
        send(6, 6, 0, 0);
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        exp_q.delete();
        pk_total = 0;
        pk_n = 0;
        idle(1);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(3, 4, 1, 1);

        send(10, 10, 1, 0);
        send(2, 3, 0, 0);
        send(1, 1, 1, 1);

        for (int i = 0; i < 20; i++) send(15, 15, 1, (i == 19));
        send(0, 0, 1, 1);

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            send(WIDTH'($urandom), WIDTH'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
        end
        rand_rdy = 1'b0;
        bus.out_ready = 1'b1;
        send(1, 2, 1, 1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk("drain_pending", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
